// File: rtl/pipe_skid_buf.sv
// pipe_skid_buf -- two-entry skid buffer for a valid/ready pipeline stage.
//
// A main register (MAIN) drives the downstream payload directly and a skid
// register (SKID) catches the one extra beat that can arrive while the
// upstream side still sees in_ready=1 from the previous cycle. Because
// in_ready comes straight from a flop, the downstream out_ready never reaches
// the upstream side combinationally, which breaks the long ready chain.
//
// Ports
//   clk        clock, rising edge
//   rst        asynchronous reset, active low
//   flush      synchronous discard of all buffered entries (highest priority)
//   in_valid   upstream payload valid
//   in_ready   buffer can accept (registered)
//   in_data    upstream payload, NBIT wide
//   out_valid  downstream payload valid
//   out_ready  downstream accepts
//   out_data   downstream payload, driven from MAIN
//   occupancy  entries held: 0, 1 or 2
//   stall_cnt  saturating count of cycles with out_valid=1 and out_ready=0
module pipe_skid_buf #(
  parameter int NBIT  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [NBIT-1:0]  in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [NBIT-1:0]  out_data,
  output logic [1:0]       occupancy,
  output logic [CNT_W-1:0] stall_cnt
);

  // State encoding doubles as the occupancy count.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [NBIT-1:0]   main_q,  main_d;
  logic [NBIT-1:0]   skid_q,  skid_d;
  logic              in_ready_q, in_ready_d;
  logic [CNT_W-1:0]  stall_q, stall_d;

  logic              in_fire;
  logic              out_fire;

  assign out_valid = (state_q != ST_EMPTY);
  assign in_fire   = in_valid & in_ready_q;
  assign out_fire  = out_valid & out_ready;

  // ---------------------------------------------------------------------
  // Next-state / datapath
  // ---------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;

    if (flush) begin
      // Register contents are left alone; only the state matters after a
      // flush, and a concurrent in_fire is simply not captured.
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (in_fire) begin
            state_d = ST_ONE;
            main_d  = in_data;
          end
        end
        ST_ONE: begin
          if (in_fire && out_fire) begin
            // Pass-through: MAIN is consumed and refilled on the same edge.
            main_d = in_data;
          end else if (in_fire) begin
            state_d = ST_FULL;
            skid_d  = in_data;
          end else if (out_fire) begin
            state_d = ST_EMPTY;
          end
        end
        ST_FULL: begin
          // in_ready is low here, so in_fire cannot occur.
          if (out_fire) begin
            state_d = ST_ONE;
            main_d  = skid_q;
          end
        end
        default: begin
          // Unused encoding: recover to a clean empty buffer.
          state_d = ST_EMPTY;
        end
      endcase
    end

    // Ready for the next cycle is decided purely from our own next state,
    // so there is no combinational out_ready -> in_ready path.
    in_ready_d = (state_d != ST_FULL);
  end

  // ---------------------------------------------------------------------
  // FSM and registered outputs
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_EMPTY;
      main_q     <= '0;
      skid_q     <= '0;
      // Held low through reset; rises on the first edge afterwards.
      in_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      main_q     <= main_d;
      skid_q     <= skid_d;
      in_ready_q <= in_ready_d;
    end
  end

  // ---------------------------------------------------------------------
  // Stall counter: saturating, only cleared by reset (flush leaves it).
  // ---------------------------------------------------------------------
  always_comb begin
    stall_d = stall_q;
    if (out_valid && !out_ready && (stall_q != {CNT_W{1'b1}}))
      stall_d = stall_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) stall_q <= '0;
    else      stall_q <= stall_d;
  end

  assign in_ready  = in_ready_q;
  assign out_data  = main_q;
  assign occupancy = state_q;
  assign stall_cnt = stall_q;

endmodule

// File: tb/tb_pipe_skid_buf.sv
// Bench for pipe_skid_buf. A queue-based reference model holds the payloads
// the buffer should currently contain (in acceptance order). The model
// process pushes on accept and clears on flush/reset; the negedge monitor
// compares the DUT outputs against the queue and pops on every output fire.
module tb_pipe_skid_buf;
  localparam int NBIT  = 16;
  localparam int CNT_W = 4;
  localparam logic [CNT_W-1:0] SAT = {CNT_W{1'b1}};

  logic             clk = 1'b0;
  logic             rst;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [NBIT-1:0]  in_data;
  logic             out_valid;
  logic             out_ready;
  logic [NBIT-1:0]  out_data;
  logic [1:0]       occupancy;
  logic [CNT_W-1:0] stall_cnt;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [NBIT-1:0]  sb_q[$];
  logic             m_ready;
  logic [CNT_W-1:0] m_stall;
  logic             stall_pend;

  pipe_skid_buf #(.NBIT(NBIT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .occupancy(occupancy), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: capacity-2 FIFO semantics.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      sb_q.delete();
      m_ready = 1'b0;
      m_stall = '0;
    end else begin
      if (stall_pend && m_stall != SAT) m_stall = m_stall + 1'b1;
      if (flush) begin
        sb_q.delete();
        m_ready = 1'b1;
      end else begin
        if (in_valid && m_ready) sb_q.push_back(in_data);
        m_ready = (sb_q.size() < 2);
      end
    end
  end

  // Monitor: compare mid-cycle, then consume the head if it leaves this edge.
  always @(negedge clk) begin
    automatic int sz = sb_q.size();
    chk("occupancy", occupancy, sz);
    chk("out_valid", out_valid, (sz != 0));
    chk("in_ready",  in_ready,  m_ready);
    chk("stall_cnt", stall_cnt, m_stall);
    if (!rst) chk("rst_out_data", out_data, 0);
    if (sz > 0) chk("out_data", out_data, sb_q[0]);
    if (rst && sz > 0 && out_ready && !flush) void'(sb_q.pop_front());
    stall_pend = rst && (sz > 0) && !out_ready;
  end

  // Inputs are applied 2 time units after a rising edge and held across the
  // next one; the task returns 2 units after that edge.
  task automatic drive(input logic v, input logic [NBIT-1:0] d, input logic ordy, input logic fl);
    in_valid  = v;
    in_data   = d;
    out_ready = ordy;
    flush     = fl;
    @(posedge clk);
    #2;
  endtask

  initial begin
    stall_pend = 1'b0;
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    chk("reset_in_ready",  in_ready, 0);
    chk("reset_occupancy", occupancy, 0);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_out_data",  out_data, 0);
    chk("reset_stall",     stall_cnt, 0);
    rst = 1'b1;

    // First edge after release must not accept.
    drive(1'b1, 16'h0099, 1'b1, 1'b0);
    chk("post_rst_in_ready", in_ready, 1);
    chk("post_rst_no_accept", occupancy, 0);

    // Stall saturation.
    drive(1'b1, 16'h003C, 1'b0, 1'b0);
    for (int i = 1; i <= 20; i++) begin
      drive(1'b0, 16'h0000, 1'b0, 1'b0);
      if (i == 5)  chk("stall_5", stall_cnt, 5);
      if (i == 20) chk("stall_sat", stall_cnt, 15);
    end
    chk("stall_hold_data", out_data, 16'h003C);

    // Async reset while full.
    drive(1'b1, 16'h0044, 1'b0, 1'b0);
    chk("full_occ", occupancy, 2);
    in_valid = 1'b0;
    #2 rst = 1'b0;
    #1;
    chk("async_out_valid", out_valid, 0);
    chk("async_in_ready",  in_ready, 0);
    chk("async_occ",       occupancy, 0);
    chk("async_stall",     stall_cnt, 0);
    #3 rst = 1'b1;
    @(posedge clk);
    #2;
    chk("rel_in_ready", in_ready, 1);
    chk("rel_occ",      occupancy, 0);

    // Streaming.
    drive(1'b1, 16'h0011, 1'b1, 1'b0);
    chk("stream_d1", out_data, 16'h0011);
    drive(1'b1, 16'h0022, 1'b1, 1'b0);
    chk("stream_d2", out_data, 16'h0022);
    chk("stream_occ", occupancy, 1);
    drive(1'b1, 16'h0033, 1'b1, 1'b0);
    chk("stream_d3", out_data, 16'h0033);
    chk("stream_rdy", in_ready, 1);
    drive(1'b0, 16'h0000, 1'b1, 1'b0);
    chk("stream_drain", occupancy, 0);

    // Backpressure fill and drain.
    drive(1'b1, 16'h000A, 1'b0, 1'b0);
    drive(1'b1, 16'h000B, 1'b0, 1'b0);
    chk("bp_occ", occupancy, 2);
    chk("bp_rdy", in_ready, 0);
    chk("bp_head", out_data, 16'h000A);
    drive(1'b0, 16'h0000, 1'b1, 1'b0);
    chk("bp_second", out_data, 16'h000B);
    drive(1'b0, 16'h0000, 1'b1, 1'b0);
    chk("bp_empty", occupancy, 0);

    // Simultaneous in/out while holding one.
    drive(1'b1, 16'h0005, 1'b0, 1'b0);
    drive(1'b1, 16'h0006, 1'b1, 1'b0);
    chk("pass_data", out_data, 16'h0006);
    chk("pass_occ", occupancy, 1);
    drive(1'b0, 16'h0000, 1'b1, 1'b0);

    // Flush while full with a concurrent input.
    drive(1'b1, 16'h0001, 1'b0, 1'b0);
    drive(1'b1, 16'h0002, 1'b0, 1'b0);
    drive(1'b1, 16'h0007, 1'b0, 1'b1);
    chk("flush_occ", occupancy, 0);
    chk("flush_valid", out_valid, 0);
    chk("flush_rdy", in_ready, 1);
    drive(1'b0, 16'h0000, 1'b1, 1'b0);
    chk("flush_nothing", out_valid, 0);

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      drive(1'($urandom_range(0, 1)), NBIT'($urandom),
            ($urandom_range(0, 9) < 6), ($urandom_range(0, 29) == 0));
    end
    for (int i = 0; i < 4; i++) drive(1'b0, 16'h0000, 1'b1, 1'b0);
    chk("final_empty", occupancy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/pipe_skid_buf.md
PIPE_SKID_BUF -- requirements
Module: pipe_skid_buf

Interface
REQ-001 Parameter: NBIT, default 32, payload width in bits; legal range 1..128.
REQ-002 Parameter: CNT_W, default 16, width of the stall counter.
REQ-003 clk  input  1  clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 flush  input  1  synchronous discard of all buffered entries.
REQ-006 in_valid  input  1  upstream payload valid.
REQ-007 in_ready  output  1  buffer can accept; driven directly from a flop.
REQ-008 in_data  input  NBIT  upstream payload.
REQ-009 out_valid  output  1  downstream payload valid.
REQ-010 out_ready  input  1  downstream accepts.
REQ-011 out_data  output  NBIT  downstream payload; driven from the main register.
REQ-012 occupancy  output  2  entries held: 0, 1 or 2.
REQ-013 stall_cnt  output  CNT_W  saturating count of cycles with out_valid=1 and out_ready=0.

Function
REQ-014 in_fire = in_valid & in_ready; out_fire = out_valid & out_ready; a transfer happens only on a fire.
REQ-015 Storage: one main register (MAIN) and one skid register (SKID), each NBIT wide.
REQ-016 States: EMPTY (occupancy 0), ONE (1), FULL (2); occupancy equals the state encoding.
REQ-017 out_valid = 1 in ONE and FULL; out_valid = 0 in EMPTY.
REQ-018 in_ready is registered and is 1 in EMPTY and ONE, 0 in FULL; it has no combinational path from out_ready.
REQ-019 EMPTY: in_fire -> ONE, MAIN <= in_data; otherwise hold.
REQ-020 ONE: in_fire & out_fire -> ONE, MAIN <= in_data; in_fire only -> FULL, SKID <= in_data; out_fire only -> EMPTY; neither -> hold.
REQ-021 FULL: out_fire -> ONE, MAIN <= SKID; otherwise hold; in_valid is ignored because in_ready = 0.
REQ-022 Latency: data accepted on edge N appears on out_data with out_valid = 1 after edge N; sustained throughput is 1 transfer per cycle while out_ready = 1.
REQ-023 Ordering: payloads leave in exactly the order accepted; none is duplicated or dropped except by flush.
REQ-024 While out_valid = 1 and out_ready = 0, out_data remains stable.
REQ-025 flush has the highest priority. At the edge it is sampled high:
- next state is EMPTY;
- in_ready becomes 1;
- any concurrent in_fire is discarded;
- MAIN and SKID contents are don't-care.
REQ-026 stall_cnt increments by 1 on each edge where out_valid = 1 and out_ready = 0.
- It saturates at all-ones and does not wrap.
- It is unaffected by flush.

Reset
REQ-027 While rst = 0, the block is held as follows:
- state EMPTY, occupancy = 0, out_valid = 0;
- in_ready = 0;
- MAIN = 0, SKID = 0, out_data = 0;
- stall_cnt = 0.
REQ-028 in_ready rises to 1 on the first rising clk edge after rst deasserts; no transfer is accepted before that edge.
REQ-029 If rst asserts mid-operation, all buffered entries are lost immediately, without waiting for a clock edge.

Verification
REQ-030 Streaming: out_ready = 1, inputs 0x11, 0x22, 0x33 on consecutive cycles -> out_data 0x11, 0x22, 0x33 one cycle later each; occupancy stays 1; in_ready stays 1.
REQ-031 Backpressure fill: out_ready = 0, send 0xA then 0xB -> occupancy 2, in_ready = 0, out_data = 0xA; then out_ready = 1 for 2 cycles -> 0xA, 0xB delivered in order, occupancy 0.
REQ-032 Simultaneous in/out in ONE: hold 0x5, then in_data = 0x6 with out_ready = 1 -> 0x5 consumed, out_data = 0x6 next cycle, occupancy stays 1.
REQ-033 Flush in FULL with in_valid = 1 carrying 0x7 -> next cycle occupancy 0, out_valid = 0, in_ready = 1; 0x7 never appears at the output.
REQ-034 Stall saturation with CNT_W = 4: out_valid = 1 and out_ready = 0 for 20 cycles -> stall_cnt = 15 and holds.
REQ-035 Async reset mid-FULL: pull rst low between edges -> out_valid = 0 and in_ready = 0 immediately; release rst -> in_ready = 1 after one edge, occupancy 0.
